// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide unit for the OTTER EX stage.
// Fixed latency of DATAWIDTH/UNROLL + 2 cycles from accepted start to done.
module otter_muldiv #(
    parameter int DATAWIDTH = 32,
    parameter int UNROLL    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [2:0]           func3,
    input  logic [DATAWIDTH-1:0] srcA,
    input  logic [DATAWIDTH-1:0] srcB,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] result
);

    localparam int W  = DATAWIDTH;
    localparam int N  = W / UNROLL;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [W-1:0]     r_mcand;
    logic [W-1:0]     r_dvsr;
    logic [2*W-1:0]   r_prod;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quo;
    logic             r_negp;
    logic             r_negq;
    logic             r_negr;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_result;

    logic             w_is_div;
    logic             w_sa;
    logic             w_sb;
    logic             w_na;
    logic             w_nb;
    logic [W-1:0]     w_abs_a;
    logic [W-1:0]     w_abs_b;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Operand signedness: MUL only needs the low half, so it runs unsigned.
    assign w_is_div = func3[2];
    assign w_sa     = w_is_div ? ~func3[0]
                               : (func3[1:0] == 2'b01) || (func3[1:0] == 2'b10);
    assign w_sb     = w_is_div ? ~func3[0] : (func3[1:0] == 2'b01);
    assign w_na     = w_sa & srcA[W-1];
    assign w_nb     = w_sb & srcB[W-1];
    assign w_abs_a  = w_na ? -srcA : srcA;
    assign w_abs_b  = w_nb ? -srcB : srcB;

    logic [2*W-1:0]   w_prod_n;
    logic [W-1:0]     w_rem_n;
    logic [W-1:0]     w_quo_n;
    logic [W:0]       w_hsum;
    logic [W:0]       w_shift;

    // UNROLL shift-add and restoring-divide steps per CALC cycle.
    always_comb begin
        w_prod_n = r_prod;
        w_rem_n  = r_rem;
        w_quo_n  = r_quo;
        w_hsum   = '0;
        w_shift  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            w_hsum   = {1'b0, w_prod_n[2*W-1:W]}
                     + (w_prod_n[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
            w_prod_n = {w_hsum, w_prod_n[W-1:1]};
            w_shift  = {w_rem_n, w_quo_n[W-1]};
            if (w_shift >= {1'b0, r_dvsr}) begin
                w_rem_n = w_shift[W-1:0] - r_dvsr;
                w_quo_n = {w_quo_n[W-2:0], 1'b1};
            end else begin
                w_rem_n = w_shift[W-1:0];
                w_quo_n = {w_quo_n[W-2:0], 1'b0};
            end
        end
    end

    logic [2*W-1:0]   w_pfull;
    logic [W-1:0]     w_qfix;
    logic [W-1:0]     w_rfix;
    logic [W-1:0]     w_fix;

    assign w_pfull = r_negp ? -r_prod : r_prod;
    assign w_qfix  = r_dz ? {W{1'b1}} : (r_negq ? -r_quo : r_quo);
    assign w_rfix  = r_negr ? -r_rem : r_rem;

    always_comb begin
        w_fix = w_rfix;
        case (r_op)
            3'b000:                 w_fix = w_pfull[W-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_pfull[2*W-1:W];
            3'b100, 3'b101:         w_fix = w_qfix;
            default:                w_fix = w_rfix;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_mcand  <= '0;
            r_dvsr   <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_negp   <= 1'b0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= func3;
                        r_mcand <= w_abs_a;
                        r_dvsr  <= w_abs_b;
                        r_prod  <= {{W{1'b0}}, w_abs_b};
                        r_quo   <= w_abs_a;
                        r_rem   <= '0;
                        r_negp  <= w_na ^ w_nb;
                        r_negq  <= w_na ^ w_nb;
                        r_negr  <= w_na;
                        r_dz    <= (srcB == '0);
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_prod <= w_prod_n;
                    r_rem  <= w_rem_n;
                    r_quo  <= w_quo_n;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/otter_muldiv.md
OTTER_MULDIV -- requirements
Module: otter_muldiv

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter UNROLL, default 1, quotient/product bits resolved per CALC cycle (1, 2 or 4; divides DATAWIDTH).
REQ-003 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL have port func3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port srcA  input  DATAWIDTH  rs1 operand (dividend / multiplicand).
REQ-008 SHALL have port srcB  input  DATAWIDTH  rs2 operand (divisor / multiplier).
REQ-009 SHALL have port flush  input  1  abort in-flight op (EX-stage flush).
REQ-010 SHALL have port busy  output  1  op in progress; drives the EX stall.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  DATAWIDTH  op result; held until next accepted start.

Function
REQ-013 SHALL implement FSM IDLE, CALC, FIX, DONE; IDLE->CALC on start; CALC->FIX after N=DATAWIDTH/UNROLL cycles; FIX->DONE; DONE->IDLE, or DONE->CALC if start.
REQ-014 SHALL latch func3, srcA, srcB on accept; later input changes do not affect the op.
REQ-015 SHALL have fixed latency: start high in cycle 0 -> done high in cycle N+2 (cycle 34 at defaults), independent of operand values.
REQ-016 SHALL hold busy=1 in CALC and FIX, 0 in IDLE and DONE; done=1 only in DONE.
REQ-017 SHALL ignore start while busy=1 (no queueing, latched operands unchanged).
REQ-018 SHALL compute a multiply as a shift-add over absolute values with a 2*DATAWIDTH-bit product; MUL returns low half; MULH/MULHSU/MULHU return high half with signs per RV32M (MULHSU: srcA signed, srcB unsigned).
REQ-019 SHALL compute a divide as restoring or non-restoring division over absolute values; FIX applies sign: quotient negative iff operand signs differ, remainder takes dividend sign (signed ops only).
REQ-020 SHALL on divisor zero return quotient all-ones (DIV, DIVU) and remainder = srcA (REM, REMU), still at the REQ-015 latency.
REQ-021 SHALL on signed overflow (srcA = most-negative, srcB = -1) return DIV = most-negative and REM = 0.
REQ-022 SHALL on flush=1 in any state go to IDLE next cycle with busy=0, done=0, result unchanged; flush takes priority over start in the same cycle.
REQ-023 SHALL, in the DONE cycle with start=1 and flush=0, pulse done for the finished op and accept the new op (back-to-back, no bubble).
REQ-024 SHALL keep all arithmetic internal; no outputs other than busy, done, result.

Reset
REQ-025 SHALL, when RESET=0 at a rising edge, enter IDLE with busy=0, done=0, result=0 and clear internal accumulators, overriding start and flush.
REQ-026 SHALL on reset asserted mid-CALC abandon the op with no done pulse; the first start after RESET=1 is accepted normally.

Verification
REQ-027 SHALL pass: MUL 0x00000007 x 0xFFFFFFFD -> done at cycle 34, result 0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-028 SHALL pass: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-029 SHALL pass: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-030 SHALL pass: start at cycle 0, flush at cycle 10 -> busy=0 from cycle 11, no done, result keeps prior value; new start cycle 12 -> done cycle 46.
REQ-031 SHALL pass: start held high cycles 0-40 with changing srcA -> first result from cycle-0 operands at cycle 34, second op accepted in cycle 34, done cycle 68.
REQ-032 SHALL pass: RESET=0 at cycle 15 of a DIV -> busy=0, done=0, result=0 next cycle; random 10k-op sweep at UNROLL=1,2,4 matches the RV32M reference model with latency N+2.
